// File: rtl/usfft_pkg.sv
// Shared types and width helpers for the unary stochastic FFT collector.
package usfft_pkg;

   typedef enum logic [1:0] {IDLE, COUNT, VALID} state_t;

   localparam int L_CREAL0 = 0;
   localparam int L_CIMG0  = 1;
   localparam int L_CREAL1 = 2;
   localparam int L_CIMG1  = 3;
   localparam int L_DREAL0 = 4;
   localparam int L_DIMG0  = 5;
   localparam int L_DREAL1 = 6;
   localparam int L_DIMG1  = 7;

   function automatic int ow_of(input int bw);
      return bw + 2;
   endfunction

   function automatic int cw_of(input int bw);
      return bw + 1;
   endfunction

endpackage

// File: rtl/usfft_lane_counter.sv
// Single-lane ones counter; result is the window total including this cycle's bit.
// USFFT_BIPOLAR_EN selects the signed 2*count-N decode.
module usfft_lane_counter
   import usfft_pkg::*;
#(
   parameter int BITWIDTH = 8
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         en,
   input  logic                         stream,
   output logic [ow_of(BITWIDTH)-1:0]   result
);

   localparam int CW = cw_of(BITWIDTH);
   localparam int OW = ow_of(BITWIDTH);

   logic [CW-1:0] cnt;
   logic [CW-1:0] sum;

   assign sum = cnt + CW'(stream);

   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (en)
         cnt <= sum;
   end

`ifdef USFFT_BIPOLAR_EN
   localparam logic [OW-1:0] N_OW = OW'(1) << BITWIDTH;
   assign result = {sum, 1'b0} - N_OW;
`else
   assign result = {1'b0, sum};
`endif

endmodule

// File: rtl/usfft_stream_collector.sv
// Counts ones on the 8 FFT output streams over a 2^BITWIDTH window.
// Build with USFFT_BIPOLAR_EN for signed lane results.
module usfft_stream_collector
   import usfft_pkg::*;
#(
   parameter int BITWIDTH = 8,
   parameter int NLANE    = 8
) (
   input  logic                            iClk,
   input  logic                            iRst,
   input  logic                            iClr,
   input  logic                            iStart,
   input  logic [NLANE-1:0]                iBits,
   input  logic                            iReady,
   output logic                            oBusy,
   output logic                            oValid,
   output logic [NLANE*(BITWIDTH+2)-1:0]   oData
);

   localparam int CW = cw_of(BITWIDTH);
   localparam int OW = ow_of(BITWIDTH);
   localparam int N  = 1 << BITWIDTH;

   state_t            state;
   logic [CW-1:0]     wcnt;
   logic              last;
   logic              start_go;
   logic              lane_clr;
   logic              lane_en;
   logic [NLANE*OW-1:0] lane_res;

   assign last     = (wcnt == CW'(N - 1));
   assign start_go = iStart &&
                     ((state == IDLE) ||
                      (state == VALID && iReady));
   assign lane_clr = iRst || iClr || start_go;
   assign lane_en  = (state == COUNT);

   for (genvar k = 0; k < NLANE; k++) begin : g_lane
      usfft_lane_counter #(
         .BITWIDTH (BITWIDTH)
      ) u_lane (
         .clk    (iClk),
         .clr    (lane_clr),
         .en     (lane_en),
         .stream (iBits[k]),
         .result (lane_res[k*OW +: OW])
      );
   end

   always_ff @(posedge iClk) begin
      if (iRst || iClr) begin
         state  <= IDLE;
         oBusy  <= 1'b0;
         oValid <= 1'b0;
         oData  <= '0;
         wcnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (iStart) begin
                  state <= COUNT;
                  oBusy <= 1'b1;
                  wcnt  <= '0;
               end
            end
            COUNT: begin
               wcnt <= wcnt + 1'b1;
               if (last) begin
                  state  <= VALID;
                  oBusy  <= 1'b0;
                  oValid <= 1'b1;
                  oData  <= lane_res;
               end
            end
            VALID: begin
               if (iReady) begin
                  oValid <= 1'b0;
                  // accept and restart in one cycle for back-to-back windows
                  if (iStart) begin
                     state <= COUNT;
                     oBusy <= 1'b1;
                     wcnt  <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usfft_stream_collector.sv
// Directed self-checking bench for usfft_stream_collector (BITWIDTH=8).
module tb_usfft_stream_collector;
   import usfft_pkg::*;

   localparam int BW = 8;
   localparam int NL = 8;
   localparam int OW = BW + 2;
   localparam int N  = 1 << BW;

   logic              iClk = 1'b0;
   logic              iRst = 1'b1;
   logic              iClr = 1'b0;
   logic              iStart = 1'b0;
   logic [NL-1:0]     iBits = '0;
   logic              iReady = 1'b0;
   logic              oBusy;
   logic              oValid;
   logic [NL*OW-1:0]  oData;

   int n_cmp = 0;
   int n_err = 0;

   usfft_stream_collector #(
      .BITWIDTH (BW),
      .NLANE    (NL)
   ) dut (
      .iClk   (iClk),
      .iRst   (iRst),
      .iClr   (iClr),
      .iStart (iStart),
      .iBits  (iBits),
      .iReady (iReady),
      .oBusy  (oBusy),
      .oValid (oValid),
      .oData  (oData)
   );

   always #5 iClk = ~iClk;

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [95:0] obs,
                      input logic [95:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [NL-1:0] bits_for(input int mode, input int i);
      logic [NL-1:0] b;
      logic [7:0]    iv;
      b  = '0;
      iv = 8'(i);
      case (mode)
         0: b = '1;
         1: b = '0;
         2: begin
            b[L_CIMG1] = (i % 2 == 0);
            b[L_DIMG0] = (i % 4 == 0);
         end
         default: b = iv ^ 8'h5A;
      endcase
      return b;
   endfunction

   function automatic logic [OW-1:0] lane_val(input int c);
`ifdef USFFT_BIPOLAR_EN
      return OW'(2 * c - N);
`else
      return OW'(c);
`endif
   endfunction

   function automatic logic [NL*OW-1:0] exp_vec(input int mode);
      logic [NL*OW-1:0] v;
      int c;
      v = '0;
      for (int k = 0; k < NL; k++) begin
         c = 0;
         if (mode == 0) c = N;
         if (mode == 2 && k == L_CIMG1) c = N / 2;
         if (mode == 2 && k == L_DIMG0) c = N / 4;
         v[k*OW +: OW] = lane_val(c);
      end
      return v;
   endfunction

   task automatic do_start();
      iStart = 1'b1;
      step();
      iStart = 1'b0;
      chk("busy_after_start", 96'(oBusy), 96'(1));
   endtask

   task automatic count_window(input string tag, input int mode);
      for (int i = 0; i < N; i++) begin
         iBits = bits_for(mode, i);
         step();
         if (i == N - 2)
            chk({tag, "_valid_early"}, 96'(oValid), 96'(0));
      end
      iBits = '0;
      chk({tag, "_valid"}, 96'(oValid), 96'(1));
      chk({tag, "_busy_done"}, 96'(oBusy), 96'(0));
      chk({tag, "_data"}, 96'(oData), 96'(exp_vec(mode)));
   endtask

   task automatic accept();
      iReady = 1'b1;
      step();
      iReady = 1'b0;
      chk("valid_after_accept", 96'(oValid), 96'(0));
      chk("busy_after_accept", 96'(oBusy), 96'(0));
   endtask

   initial begin
      logic [NL*OW-1:0] held;
      bit bad;

      repeat (3) step();
      chk("rst_busy", 96'(oBusy), 96'(0));
      chk("rst_valid", 96'(oValid), 96'(0));
      chk("rst_data", 96'(oData), 96'(0));
      iRst = 1'b0;
      step();

      do_start();
      count_window("ones", 0);
      accept();

      do_start();
      count_window("zeros", 1);
      accept();

      do_start();
      count_window("pattern", 2);
      accept();

      // abort at cycle 100 of a window
      do_start();
      for (int i = 0; i < 100; i++) begin
         iBits = '1;
         step();
      end
      iClr = 1'b1;
      step();
      iClr = 1'b0;
      chk("clr_busy", 96'(oBusy), 96'(0));
      chk("clr_valid", 96'(oValid), 96'(0));
      chk("clr_data", 96'(oData), 96'(0));
      bad = 1'b0;
      for (int i = 0; i < N + 20; i++) begin
         step();
         if (oValid || oBusy) bad = 1'b1;
      end
      chk("clr_stays_idle", 96'(bad), 96'(0));
      do_start();
      count_window("after_clr", 2);

      // hold under backpressure, with toggling bits and ignored starts
      held = oData;
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         iBits  = bits_for(3, i);
         iStart = (i % 7 == 3);
         step();
         if (!oValid || oBusy || oData !== held) bad = 1'b1;
      end
      iStart = 1'b0;
      iBits  = '0;
      chk("bp_hold", 96'(bad), 96'(0));
      chk("bp_data", 96'(oData), 96'(exp_vec(2)));
      accept();

      // back-to-back handoff
      do_start();
      count_window("b2b_first", 0);
      iReady = 1'b1;
      iStart = 1'b1;
      step();
      iReady = 1'b0;
      iStart = 1'b0;
      chk("b2b_busy", 96'(oBusy), 96'(1));
      chk("b2b_valid_drop", 96'(oValid), 96'(0));
      count_window("b2b_second", 1);
      accept();

      // reset mid-count
      do_start();
      for (int i = 0; i < 50; i++) begin
         iBits = '1;
         step();
      end
      iRst = 1'b1;
      step();
      chk("rst_cnt_busy", 96'(oBusy), 96'(0));
      chk("rst_cnt_valid", 96'(oValid), 96'(0));
      iRst = 1'b0;
      iBits = '0;
      step();

      // reset while holding a result
      do_start();
      count_window("pre_rst", 0);
      iRst = 1'b1;
      step();
      chk("rst_v_busy", 96'(oBusy), 96'(0));
      chk("rst_v_valid", 96'(oValid), 96'(0));
      chk("rst_v_data", 96'(oData), 96'(0));
      iRst = 1'b0;
      step();

      // no partial counts survive the resets
      do_start();
      count_window("post_rst", 2);
      accept();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/usfft_stream_collector.md
Name: usfft_stream_collector

Overview:
- Downstream stage of the 4-point unary stochastic FFT.
- Consumes its 8 output bitstreams (C/D real/imag, lanes 0/1) and counts ones in each over a fixed window of 2^BITWIDTH cycles.
- Presents the 8 binary results on a valid/ready interface for the binary back-end.
- Window start is aligned by the controller via iStart, issued the same cycle the FFT weights/streams begin.

Parameters:
- BITWIDTH, 8, stream resolution; window length N = 2^BITWIDTH cycles.
- NLANE, 8, number of input bitstreams (fixed at 8 for the 4-point FFT; not overridden).

Ports:
- iClk  input  1  clock; all logic on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iClr  input  1  synchronous abort of the current window or held result.
- iStart  input  1  begin a counting window; honoured only in IDLE or on a VALID->COUNT handoff.
- iBits  input  NLANE  lane bitstreams, order [0]=CReal0 [1]=CImg0 [2]=CReal1 [3]=CImg1 [4]=DReal0 [5]=DImg0 [6]=DReal1 [7]=DImg1.
- iReady  input  1  consumer accepts oData when oValid=1.
- oBusy  output  1  high while in COUNT.
- oValid  output  1  oData holds a completed window.
- oData  output  NLANE*(BITWIDTH+2)  per-lane result; lane k at bits [k*OW +: OW], OW = BITWIDTH+2.

Behaviour:
- Clock is iClk, single domain. Reset iRst is synchronous and active-high.
- Reset (iRst=1 at an edge): state=IDLE; oBusy=0; oValid=0; oData=0; lane counters=0; window counter=0. Reset mid-window discards all partial counts.
- FSM states and transitions:
  - IDLE: iStart=1 -> COUNT; lane counters and window counter cleared.
  - COUNT: each cycle, every lane counter adds iBits[k]; window counter increments. After exactly N cycles in COUNT, the final counts latch into oData -> VALID.
  - VALID: oValid=1 and oData stable until the handshake. iReady=1 -> IDLE. iReady=1 with iStart=1 in the same cycle -> COUNT directly (back-to-back, no bubble).
- Timing: iStart sampled at cycle t -> bits sampled in cycles t+1..t+N -> oValid=1 from cycle t+N+1. iStart during COUNT or VALID (without iReady) is ignored.
- Lane counters are BITWIDTH+1 bits wide, so 0..N is representable. They never saturate or wrap (the window caps the count at N). Window counter is BITWIDTH+1 bits.
- Unipolar output (default): oData lane = count, zero-extended to OW.
- iClr=1: from any state -> IDLE; counters cleared; oValid drops the next cycle; held oData cleared to 0. iClr takes priority over iStart and iReady.
- iRst takes priority over everything.

Optional Feature:
- Macro USFFT_BIPOLAR_EN.
- Defined: oData lane = signed two's-complement 2*count - N in OW bits, range -N..+N (bipolar stochastic decode, since the FFT outputs are signed). Conversion happens in the latch cycle, with no extra latency.
- Undefined: unipolar count as above; no subtractor logic is generated.

Decomposition:
- Shared package usfft_pkg holds:
  - state enum {IDLE, COUNT, VALID};
  - lane index constants (L_CREAL0..L_DIMG1);
  - OW/CW width helper functions, keyed on BITWIDTH.
- One sub-module, usfft_lane_counter: single-lane clear/enable ones counter with final-value output (and the bipolar convert under the macro). Instantiate it NLANE times via generate.

Test Plan:
- Reset then iStart; all lanes driven 1 for 256 cycles (BITWIDTH=8) -> oValid at t+257, every lane = 256 (bipolar: +256).
- All lanes 0 -> every lane = 0 (bipolar: -256); lane 3 driven 1010... and lane 5 driven one-in-four -> lane3=128, lane5=64 (bipolar: 0, -128).
- iClr asserted at cycle 100 of a window -> IDLE next cycle, oValid never asserts, oBusy=0; a fresh iStart gives a correct full-window count.
- Backpressure: iReady held 0 for 50 cycles after oValid, iBits toggling and iStart pulsed -> oData unchanged, no new window; iReady=1 -> IDLE.
- Back-to-back: iReady=1 and iStart=1 in the same VALID cycle -> oBusy next cycle, second result valid exactly N+1 cycles later.
- iRst asserted mid-COUNT and again during VALID -> all outputs 0 on the next cycle.
